// File: rtl/wrarb.sv
// Two-master write-bus arbiter with a registered downstream stage and round-robin grant.
// Define WRARB_PRIO_EN for fixed m0 priority with a starvation guard for m1.
module wrarb #(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_wraddr,
    input  logic [DW-1:0] m0_wrdata,
    input  logic          m0_wrvalid,
    output logic          m0_wrready,
    input  logic [AW-1:0] m1_wraddr,
    input  logic [DW-1:0] m1_wrdata,
    input  logic          m1_wrvalid,
    output logic          m1_wrready,
    output logic [AW-1:0] s_wraddr,
    output logic [DW-1:0] s_wrdata,
    output logic          s_wrvalid,
    input  logic          s_wrready,
    output logic          s_wrsrc
);

    logic slot_free;
    logic any_valid;
    logic accept;
    logic grant;

`ifdef WRARB_PRIO_EN
    logic [3:0] starve_q;

    // m0 wins unless m1 has lost fifteen contested rounds in a row.
    always_comb begin
        grant = 1'b0;
        if (m1_wrvalid && (!m0_wrvalid || starve_q == 4'hF)) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else if (m1_wrready) begin
            starve_q <= 4'd0;
        end else if (m0_wrready && m1_wrvalid) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic last_q;

    always_comb begin
        grant = 1'b0;
        if (m0_wrvalid && m1_wrvalid) begin
            grant = !last_q;
        end else if (m1_wrvalid) begin
            grant = 1'b1;
        end
    end

    // Reset to 1 so m0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant;
        end
    end
`endif

    assign slot_free  = !s_wrvalid | s_wrready;
    assign any_valid  = m0_wrvalid | m1_wrvalid;
    assign accept     = slot_free & any_valid & !rst;
    assign m0_wrready = accept & !grant;
    assign m1_wrready = accept & grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_wrvalid <= 1'b0;
            s_wraddr  <= '0;
            s_wrdata  <= '0;
            s_wrsrc   <= 1'b0;
        end else if (accept) begin
            s_wrvalid <= 1'b1;
            s_wraddr  <= grant ? m1_wraddr : m0_wraddr;
            s_wrdata  <= grant ? m1_wrdata : m0_wrdata;
            s_wrsrc   <= grant;
        end else if (s_wrready) begin
            s_wrvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wrarb.sv
// Directed self-checking bench for wrarb; the WRARB_PRIO_EN build runs the priority sequence
// in place of the round-robin and backpressure sequences.
module tb_wrarb;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_wraddr, m1_wraddr, s_wraddr;
    logic [DW-1:0] m0_wrdata, m1_wrdata, s_wrdata;
    logic          m0_wrvalid, m1_wrvalid, m0_wrready, m1_wrready;
    logic          s_wrvalid, s_wrready, s_wrsrc;

    int checks = 0;
    int failures = 0;

    wrarb #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_wraddr  (m0_wraddr),
        .m0_wrdata  (m0_wrdata),
        .m0_wrvalid (m0_wrvalid),
        .m0_wrready (m0_wrready),
        .m1_wraddr  (m1_wraddr),
        .m1_wrdata  (m1_wrdata),
        .m1_wrvalid (m1_wrvalid),
        .m1_wrready (m1_wrready),
        .s_wraddr   (s_wraddr),
        .s_wrdata   (s_wrdata),
        .s_wrvalid  (s_wrvalid),
        .s_wrready  (s_wrready),
        .s_wrsrc    (s_wrsrc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int acc0;
    int acc1;
    logic exp_src;

    initial begin
        rst        = 1'b1;
        s_wrready  = 1'b0;
        m0_wraddr  = 17'h00010;
        m0_wrdata  = 9'h1A5;
        m0_wrvalid = 1'b1;
        m1_wraddr  = 17'h1FFFF;
        m1_wrdata  = 9'h1FF;
        m1_wrvalid = 1'b0;
        repeat (2) tick();

        // Reset state, readies held low during reset even with a request present.
        check_eq("rst_valid", s_wrvalid, 0);
        check_eq("rst_addr", s_wraddr, 0);
        check_eq("rst_data", s_wrdata, 0);
        check_eq("rst_src", s_wrsrc, 0);
        check_eq("rst_rdy0", m0_wrready, 0);
        check_eq("rst_rdy1", m1_wrready, 0);

        // Single master after release.
        rst       = 1'b0;
        s_wrready = 1'b1;
        #1;
        check_eq("single_rdy0", m0_wrready, 1);
        check_eq("single_rdy1", m1_wrready, 0);
        tick();
        m0_wrvalid = 1'b0;
        check_eq("single_valid", s_wrvalid, 1);
        check_eq("single_addr", s_wraddr, 32'h10);
        check_eq("single_data", s_wrdata, 32'h1A5);
        check_eq("single_src", s_wrsrc, 0);

        // Drain: no requests, beat leaves, address holds.
        tick();
        check_eq("drain_valid", s_wrvalid, 0);
        check_eq("drain_addr", s_wraddr, 32'h10);
        check_eq("drain_data", s_wrdata, 32'h1A5);
        tick();
        check_eq("idle_valid", s_wrvalid, 0);

        // Reset pulse restores the tie-break pointer.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        m0_wraddr  = 17'h00100;
        m0_wrdata  = 9'h011;
        m0_wrvalid = 1'b1;
        m1_wrvalid = 1'b1;
        s_wrready  = 1'b1;

`ifdef WRARB_PRIO_EN
        for (int k = 0; k < 32; k++) begin
            exp_src = (k % 16) == 15;
            check_eq($sformatf("prio_rdy1_%0d", k), m1_wrready, exp_src);
            tick();
            check_eq($sformatf("prio_src_%0d", k), s_wrsrc, exp_src);
        end
        m1_wrvalid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check_eq($sformatf("solo_rdy0_%0d", k), m0_wrready, 1);
            tick();
            check_eq($sformatf("solo_src_%0d", k), s_wrsrc, 0);
            check_eq($sformatf("solo_valid_%0d", k), s_wrvalid, 1);
        end
`else
        // Alternation with both masters valid.
        acc0 = 0;
        acc1 = 0;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_src = k[0];
            if (m0_wrready) acc0++;
            if (m1_wrready) acc1++;
            tick();
            check_eq($sformatf("alt_src_%0d", k), s_wrsrc, exp_src);
            check_eq($sformatf("alt_addr_%0d", k), s_wraddr, exp_src ? 32'h1FFFF : 32'h100);
        end
        check_eq("alt_acc0", acc0, 3);
        check_eq("alt_acc1", acc1, 3);

        // Backpressure: pending m1 beat frozen, no readies.
        s_wrready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("bp_rdy0_%0d", k), m0_wrready, 0);
            check_eq($sformatf("bp_rdy1_%0d", k), m1_wrready, 0);
            tick();
            check_eq($sformatf("bp_valid_%0d", k), s_wrvalid, 1);
            check_eq($sformatf("bp_src_%0d", k), s_wrsrc, 1);
            check_eq($sformatf("bp_addr_%0d", k), s_wraddr, 32'h1FFFF);
            check_eq($sformatf("bp_data_%0d", k), s_wrdata, 32'h1FF);
        end
        s_wrready = 1'b1;
        #1;
        check_eq("bp_rel_rdy0", m0_wrready, 1);
        check_eq("bp_rel_rdy1", m1_wrready, 0);
        tick();
        check_eq("bp_rel_src", s_wrsrc, 0);
        check_eq("bp_rel_addr", s_wraddr, 32'h100);
`endif

        // Reset mid-cycle with a stalled beat; m0 must win the next tie.
        m0_wrvalid = 1'b0;
        m1_wrvalid = 1'b0;
        s_wrready  = 1'b0;
        #2;
        check_eq("mid_pre_valid", s_wrvalid, 1);
        rst = 1'b1;
        #1;
        check_eq("mid_valid", s_wrvalid, 0);
        check_eq("mid_rdy0", m0_wrready, 0);
        #2;
        rst        = 1'b0;
        m0_wrvalid = 1'b1;
        m1_wrvalid = 1'b1;
        s_wrready  = 1'b1;
        #1;
        check_eq("post_rdy0", m0_wrready, 1);
        check_eq("post_rdy1", m1_wrready, 0);
        tick();
        check_eq("post_src", s_wrsrc, 0);
        check_eq("post_valid", s_wrvalid, 1);

        // Only m1 requesting.
        m0_wrvalid = 1'b0;
        m1_wraddr  = 17'h0ABCD;
        m1_wrdata  = 9'h05A;
        #1;
        check_eq("m1only_rdy1", m1_wrready, 1);
        check_eq("m1only_rdy0", m0_wrready, 0);
        tick();
        m1_wrvalid = 1'b0;
        check_eq("m1only_src", s_wrsrc, 1);
        check_eq("m1only_addr", s_wraddr, 32'h0ABCD);
        check_eq("m1only_data", s_wrdata, 32'h05A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wrarb.md
Name: wrarb

Overview:
- Two-master write-bus arbiter: shares one downstream write port between two requesters.
- Example masters: the CPU and a future VGA scroll/clear engine.
- Sits in front of the write switch, replacing the direct CPU-to-switch connection.
- Registered output stage with valid/ready handshake on every side.
- Round-robin grant; sustains one transfer per clock.

Parameters:
- AW, 17, write address width.
- DW, 9, write data width.

Ports:
- clk  in  1  system clock (vclk domain).
- rst  in  1  asynchronous, active-high reset.
- m0_wraddr  in  AW  master 0 address.
- m0_wrdata  in  DW  master 0 data.
- m0_wrvalid  in  1  master 0 request.
- m0_wrready  out  1  master 0 accept.
- m1_wraddr  in  AW  master 1 address.
- m1_wrdata  in  DW  master 1 data.
- m1_wrvalid  in  1  master 1 request.
- m1_wrready  out  1  master 1 accept.
- s_wraddr  out  AW  downstream address (registered).
- s_wrdata  out  DW  downstream data (registered).
- s_wrvalid  out  1  downstream request (registered).
- s_wrready  in  1  downstream accept.
- s_wrsrc  out  1  index of the master that owns the current s_* beat (registered).

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - s_wrvalid=0, s_wraddr=0, s_wrdata=0, s_wrsrc=0.
  - Round-robin pointer last=1, so m0 wins the first tie.
  - m0_wrready=m1_wrready=0 while rst is high.
- Transfer rules:
  - A master transfer occurs on a clock edge where mX_wrvalid & mX_wrready.
  - A downstream transfer occurs on an edge where s_wrvalid & s_wrready.
- Output slot free: slot_free = !s_wrvalid | s_wrready (combinational).
- Grant selection (combinational):
  - Only m0 valid -> g=0. Only m1 valid -> g=1.
  - Both valid -> g = !last (the master not served most recently).
  - Neither valid -> no grant.
- Ready generation: mX_wrready = slot_free & mX_wrvalid & (g==X) & !rst. At most one ready is high in any cycle.
- On an accepting edge:
  - s_wraddr/s_wrdata <= granted master's addr/data.
  - s_wrvalid <= 1; s_wrsrc <= g; last <= g.
- On an edge with a downstream transfer and no master accepted: s_wrvalid <= 0. Addr, data and src hold their values.
- While s_wrvalid=1 & s_wrready=0:
  - All s_* outputs are stable.
  - Both mX_wrready=0.
  - last is unchanged.
- Latency: master accept to s_wrvalid is 1 cycle.
- Throughput: back-to-back transfers (1/clk) when s_wrready is held high.
- Master-side rules:
  - A master may drop valid before it is accepted; the arbiter keeps no state for it.
  - The grant is re-evaluated every cycle.
  - Masters must hold addr/data stable while valid and not ready (masters' responsibility).
- Round-robin with both masters continuously valid and s_wrready=1: sources alternate 0,1,0,1,...
- Reset mid-transfer: the pending s_* beat is discarded (s_wrvalid=0 asynchronously) and last returns to 1.
- No combinational path from mX_wrvalid to s_* outputs. The only combinational path is s_wrready -> mX_wrready.

Optional Feature:
- Macro: WRARB_PRIO_EN.
- Defined:
  - Fixed priority; m0 always wins when valid. The last register is unused and s_wrsrc still reports the winner.
  - Starvation guard: a 4-bit counter increments on each m0 win while m1_wrvalid=1. At 15, the next grant is forced to m1 and the counter clears.
  - The counter also clears on any m1 accept. It resets to 0.
- Undefined: round-robin as above; the counter is not built.

Test Plan:
- Reset, single master:
  - After rst release, m0 writes addr=0x00010, data=0x1A5, s_wrready=1.
  - Expect m0_wrready=1 in the same cycle.
  - Next cycle: s_wrvalid=1, s_wraddr=0x00010, s_wrdata=0x1A5, s_wrsrc=0.
- Alternation:
  - Both masters valid for 6 cycles, s_wrready=1.
  - Expect s_wrsrc sequence 0,1,0,1,0,1 and exactly 3 accepts per master.
- Backpressure:
  - s_wrready=0 for 5 cycles with a beat pending and both masters valid.
  - Expect s_* frozen and both readies 0 throughout.
  - On s_wrready=1: next beat from the other master, accepted in that same cycle.
- Drain:
  - A single beat is accepted, then no requests, s_wrready=1.
  - Expect s_wrvalid to drop after one cycle; s_wraddr holds its value.
- Reset mid-op:
  - Assert rst asynchronously (mid-cycle) while s_wrvalid=1 and s_wrready=0.
  - Expect s_wrvalid=0 immediately.
  - After release, with both masters valid, m0 is granted first.
- WRARB_PRIO_EN:
  - Both masters continuously valid, s_wrready=1.
  - Expect 15 m0 beats, then 1 m1 beat, repeating; with m1 idle, m0 gets every cycle.
